// File: rtl/spi_target_sampled.sv
// SPI target running entirely in the clk domain. SCLK, CS_n and MOSI are oversampled.
// Supports all four SPI modes, DATA_W-bit words, a one-entry TX buffer and multi-word frames.
module spi_target_sampled #(
    parameter int unsigned       DATA_W    = 8,
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [DATA_W-1:0] IDLE_WORD = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun,
    output logic              frame_err
);

    localparam int unsigned        CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DATA_W);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    state_t            state, state_next;
    logic [2:0]        sclk_sync, cs_sync;
    logic [1:0]        mosi_sync;
    logic              cpol_q, cpha_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sr, rx_sr, tx_buf, load_word;
    logic              buf_full;
    logic              sclk_rise, sclk_fall, lead_edge, trail_edge, cs_fall;
    logic              load_ev, sample_ev, shift_ev, word_done, abort_err;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] r, input logic b);
        return MSB_FIRST ? {r[DATA_W-2:0], b} : {b, r[DATA_W-1:1]};
    endfunction

    // CS chain resets to "asserted" so a CS already low when reset releases never starts a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            cs_sync   <= {cs_sync[1:0], cs_n};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall  = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall    = ~cs_sync[1] & cs_sync[2];
    assign lead_edge  = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge = cpol_q ? sclk_rise : sclk_fall;
    assign load_word  = buf_full ? tx_buf : IDLE_WORD;
    assign tx_ready   = ~buf_full;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_ev    = 1'b0;
        sample_ev  = 1'b0;
        shift_ev   = 1'b0;
        word_done  = 1'b0;
        abort_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                load_ev    = 1'b1;
                state_next = cs_sync[1] ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cs_sync[1]) begin
                    state_next = ST_IDLE;
                    abort_err  = (bit_cnt != '0) && (bit_cnt != CNT_FULL);
                end else if (bit_cnt == CNT_FULL) begin
                    word_done = 1'b1;
                    load_ev   = 1'b1;
                end else if (cpha_q) begin
                    sample_ev = trail_edge;
                    shift_ev  = lead_edge;
                end else begin
                    // In mode 0/2 the trailing edge right after a word boundary must not
                    // advance past the first bit that the reload already presented.
                    sample_ev = lead_edge;
                    shift_ev  = trail_edge && (bit_cnt != '0);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miso        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            tx_buf      <= '0;
            buf_full    <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= abort_err;
            busy        <= (state_next != ST_IDLE);

            if (state == ST_IDLE && cs_fall) begin
                cpol_q <= cpol;
                cpha_q <= cpha;
            end

            // A load frees the buffer first, so a same-cycle write still lands.
            if (load_ev) buf_full <= 1'b0;
            if (tx_valid && !buf_full) begin
                buf_full <= 1'b1;
                tx_buf   <= tx_data;
            end

            if (load_ev) begin
                tx_underrun <= ~buf_full;
                if (cpha_q) begin
                    tx_sr <= load_word;
                end else begin
                    miso  <= first_bit(load_word);
                    tx_sr <= shift_out(load_word);
                end
            end

            if (shift_ev) begin
                miso  <= first_bit(tx_sr);
                tx_sr <= shift_out(tx_sr);
            end

            if (sample_ev) rx_sr <= shift_in(rx_sr, mosi_sync[1]);

            if (load_ev || state == ST_IDLE) bit_cnt <= '0;
            else if (sample_ev)              bit_cnt <= bit_cnt + CNT_W'(1);

            if (word_done) begin
                rx_data  <= rx_sr;
                rx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_target_sampled.sv
// Randomised scoreboard bench for spi_target_sampled: an 8-bit MSB-first and a 16-bit LSB-first
// instance, each driven by a behavioural SPI master and checked against a word-level model.
module tb_spi_target_sampled;

    localparam int W0 = 8;
    localparam int W1 = 16;
    localparam int H  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cpol, cpha;
    logic [1:0] sclk_v, cs_v, mosi_v;

    logic          miso0, txr0, rxv0, busy0, und0, ferr0, txv0;
    logic [W0-1:0] txd0, rxd0;
    logic          miso1, txr1, rxv1, busy1, und1, ferr1, txv1;
    logic [W1-1:0] txd1, rxd1;

    spi_target_sampled #(.DATA_W(W0), .MSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
        .sclk(sclk_v[0]), .cs_n(cs_v[0]), .mosi(mosi_v[0]), .miso(miso0),
        .tx_data(txd0), .tx_valid(txv0), .tx_ready(txr0),
        .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0),
        .tx_underrun(und0), .frame_err(ferr0)
    );

    spi_target_sampled #(.DATA_W(W1), .MSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
        .sclk(sclk_v[1]), .cs_n(cs_v[1]), .mosi(mosi_v[1]), .miso(miso1),
        .tx_data(txd1), .tx_valid(txv1), .tx_ready(txr1),
        .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1),
        .tx_underrun(und1), .frame_err(ferr1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_rx0[$], exp_rx1[$];
    logic [31:0] stream0[$], stream1[$];
    logic [31:0] feed0[$], feed1[$];
    logic [31:0] last_rx [2];
    int          und_seen [2];
    int          ferr_seen [2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic miso_now(input int sel);
        return sel != 0 ? miso1 : miso0;
    endfunction

    function automatic logic [31:0] rx_now(input int sel);
        return sel != 0 ? 32'(rxd1) : 32'(rxd0);
    endfunction

    function automatic logic txr_now(input int sel);
        return sel != 0 ? txr1 : txr0;
    endfunction

    function automatic logic busy_now(input int sel);
        return sel != 0 ? busy1 : busy0;
    endfunction

    // TX feeders: present the head of each queue and pop it on a handshake.
    initial begin
        txv0 = 1'b0;
        txd0 = '0;
        forever begin
            @(posedge clk);
            if (txv0 && txr0 && !rst && feed0.size() > 0) void'(feed0.pop_front());
            #1;
            txv0 = (feed0.size() > 0);
            if (feed0.size() > 0) txd0 = W0'(feed0[0]);
        end
    end

    initial begin
        txv1 = 1'b0;
        txd1 = '0;
        forever begin
            @(posedge clk);
            if (txv1 && txr1 && !rst && feed1.size() > 0) void'(feed1.pop_front());
            #1;
            txv1 = (feed1.size() > 0);
            if (feed1.size() > 0) txd1 = W1'(feed1[0]);
        end
    end

    // Monitor: each rx_valid strobe is matched against the oldest expected word.
    always @(negedge clk) begin
        if (!rst) begin
            if (rxv0) begin
                if (exp_rx0.size() == 0) checkOutput("rx0_unexpected", 32'd1, 32'd0);
                else                     checkOutput("rx0_data", 32'(rxd0), exp_rx0.pop_front());
            end
            if (rxv1) begin
                if (exp_rx1.size() == 0) checkOutput("rx1_unexpected", 32'd1, 32'd0);
                else                     checkOutput("rx1_data", 32'(rxd1), exp_rx1.pop_front());
            end
            if (und0)  und_seen[0]++;
            if (und1)  und_seen[1]++;
            if (ferr0) ferr_seen[0]++;
            if (ferr1) ferr_seen[1]++;
        end
    end

    task automatic pushTx(input int sel, input logic [31:0] w);
        if (sel != 0) begin
            stream1.push_back(w);
            feed1.push_back(w);
        end else begin
            stream0.push_back(w);
            feed0.push_back(w);
        end
        tick(4);
    endtask

    task automatic clearModel();
        feed0.delete();
        feed1.delete();
        stream0.delete();
        stream1.delete();
        exp_rx0.delete();
        exp_rx1.delete();
        last_rx[0] = '0;
        last_rx[1] = '0;
    endtask

    task automatic checkResetState(input int sel);
        checkOutput("rst_miso",     32'(miso_now(sel)), 32'd0);
        checkOutput("rst_tx_ready", 32'(txr_now(sel)), 32'd1);
        checkOutput("rst_rx_data",  rx_now(sel), 32'd0);
        checkOutput("rst_busy",     32'(busy_now(sel)), 32'd0);
        checkOutput("rst_rx_valid", 32'(sel != 0 ? rxv1 : rxv0), 32'd0);
        checkOutput("rst_underrun", 32'(sel != 0 ? und1 : und0), 32'd0);
        checkOutput("rst_frame_err", 32'(sel != 0 ? ferr1 : ferr0), 32'd0);
    endtask

    // One frame of nw complete words plus 'partial' trailing bits, checked word by word.
    task automatic applyStimulus(input int sel, input logic [1:0] mode, input int nw,
                                 input int partial, input logic [31:0] first_word);
        int          w, total, wi, bi, pos, und_exp, und_s, ferr_s, left;
        logic [31:0] mask, word, acc;
        logic [31:0] mo[$];
        logic [31:0] em[$];
        logic        b, m;
        w    = (sel != 0) ? W1 : W0;
        mask = (32'd1 << w) - 32'd1;
        for (int i = 0; i < nw; i++) begin
            word = ((i == 0) ? first_word : $urandom()) & mask;
            mo.push_back(word);
            if (sel != 0) exp_rx1.push_back(word);
            else          exp_rx0.push_back(word);
            last_rx[sel] = word;
        end
        // One load at frame start and one per completed word; each takes the next queued word.
        und_exp = 0;
        for (int i = 0; i <= nw; i++) begin
            if (sel != 0 && stream1.size() > 0)      word = stream1.pop_front();
            else if (sel == 0 && stream0.size() > 0) word = stream0.pop_front();
            else begin
                word = mask;
                und_exp++;
            end
            em.push_back(word);
        end
        und_s  = und_seen[sel];
        ferr_s = ferr_seen[sel];

        cpol = mode[1];
        cpha = mode[0];
        sclk_v[sel] = mode[1];
        tick(H);
        cs_v[sel] = 1'b0;
        tick(H);
        total = nw * w + partial;
        acc   = '0;
        for (int k = 0; k < total; k++) begin
            wi   = k / w;
            bi   = k % w;
            pos  = (sel != 0) ? bi : (w - 1 - bi);
            word = (wi < nw) ? mo[wi] : $urandom();
            b    = word[pos];
            if (!mode[0]) begin
                mosi_v[sel] = b;
                tick(H);
                m = miso_now(sel);
                sclk_v[sel] = ~sclk_v[sel];
                tick(H);
                sclk_v[sel] = ~sclk_v[sel];
            end else begin
                sclk_v[sel] = ~sclk_v[sel];
                mosi_v[sel] = b;
                tick(H);
                m = miso_now(sel);
                sclk_v[sel] = ~sclk_v[sel];
                tick(H);
            end
            acc[pos] = m;
            if (bi == w - 1 && wi < nw) begin
                checkOutput("miso_word", acc, em[wi]);
                acc = '0;
            end
        end
        tick(H);
        cs_v[sel] = 1'b1;
        tick(12);
        left = (sel != 0) ? stream1.size() : stream0.size();
        checkOutput("rx_pending", (sel != 0) ? 32'(exp_rx1.size()) : 32'(exp_rx0.size()), 32'd0);
        checkOutput("rx_hold", rx_now(sel), last_rx[sel]);
        checkOutput("underrun_count", 32'(und_seen[sel] - und_s), 32'(und_exp));
        checkOutput("frame_err_count", 32'(ferr_seen[sel] - ferr_s), (partial != 0) ? 32'd1 : 32'd0);
        checkOutput("busy_after", 32'(busy_now(sel)), 32'd0);
        checkOutput("tx_ready_after", 32'(txr_now(sel)), (left == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int          sel, nw, partial, np;
        logic [1:0]  mode;
        und_seen  = '{0, 0};
        ferr_seen = '{0, 0};
        last_rx   = '{32'd0, 32'd0};
        rst    = 1'b1;
        cpol   = 1'b0;
        cpha   = 1'b0;
        sclk_v = 2'b00;
        cs_v   = 2'b11;
        mosi_v = 2'b00;
        tick(4);
        rst = 1'b0;
        tick(1);
        checkResetState(0);
        checkResetState(1);

        // Mode 0, MSB first, buffered 0xA5 against master word 0x3C.
        pushTx(0, 32'hA5);
        checkOutput("tx_ready_full", 32'(txr0), 32'd0);
        applyStimulus(0, 2'd0, 1, 0, 32'h3C);

        for (int md = 1; md < 4; md++) begin
            pushTx(0, 32'h5A);
            applyStimulus(0, 2'(md), 1, 0, 32'hC3);
        end

        // Multi-word frame with a single queued word.
        pushTx(0, 32'h11);
        applyStimulus(0, 2'd0, 3, 0, 32'h96);

        // Truncated frame, then a clean one.
        applyStimulus(0, 2'd0, 0, 5, 32'h0);
        applyStimulus(0, 2'd0, 1, 0, 32'h7E);

        // Wide LSB-first word.
        pushTx(1, 32'h1234);
        applyStimulus(1, 2'd0, 1, 0, 32'h8001);
        pushTx(1, 32'hBEEF);
        applyStimulus(1, 2'd3, 2, 0, 32'h0001);

        // Reset in the middle of a word.
        cpol = 1'b0;
        cpha = 1'b0;
        sclk_v[0] = 1'b0;
        tick(H);
        cs_v[0] = 1'b0;
        tick(H);
        for (int k = 0; k < 3; k++) begin
            mosi_v[0] = 1'($urandom_range(0, 1));
            tick(H);
            sclk_v[0] = 1'b1;
            tick(H);
            sclk_v[0] = 1'b0;
        end
        clearModel();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        checkResetState(0);
        checkOutput("rst_rx_data1", 32'(rxd1), 32'd0);
        cs_v[0] = 1'b1;
        tick(H);
        applyStimulus(0, 2'd0, 1, 0, 32'h5C);

        // Randomised frames across both instances.
        for (int it = 0; it < 24; it++) begin
            sel     = $urandom_range(0, 1);
            mode    = 2'($urandom_range(0, 3));
            nw      = $urandom_range(0, 3);
            partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (sel != 0 ? W1 : W0) - 1) : 0;
            if (nw == 0 && partial == 0) nw = 1;
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) pushTx(sel, $urandom() & ((sel != 0) ? 32'hFFFF : 32'hFF));
            applyStimulus(sel, mode, nw, partial, $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
